// File: rtl/seg7_scan_if.sv
// seg7_scan_if: load/data side and display-pin side of the scanned
// seven-segment driver, bundled for seg7_scan_driver.
// master = the block that loads digits and watches the pins.
// slave  = seg7_scan_driver itself.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      digit_tick;
  logic                      frame_start;

  modport master (
    output load, data_in, dp_in, blank,
    input  seg, dp, an, digit_tick, frame_start
  );

  modport slave (
    input  load, data_in, dp_in, blank,
    output seg, dp, an, digit_tick, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment display driver.
// Digits are captured into a shadow register on load and only copied to the
// display register when the scan wraps back to digit 0, so a frame never
// shows a mix of old and new digits. All pins are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits
// (digit 0 is always shown).
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          index;
  logic [DW-1:0]          shadow_data;
  logic [NUM_DIGITS-1:0]  shadow_dp;
  logic                   pending;
  logic [DW-1:0]          disp_data;
  logic [NUM_DIGITS-1:0]  disp_dp;

  logic [6:0]             seg_q;
  logic                   dp_q;
  logic [NUM_DIGITS-1:0]  an_q;
  logic                   digit_tick_q;
  logic                   frame_start_q;

  logic                   tick;
  logic                   wrap;
  logic [IW-1:0]          idx_nxt;
  logic [DW-1:0]          disp_data_nxt;
  logic [NUM_DIGITS-1:0]  disp_dp_nxt;
  logic [3:0]             nib;
  logic                   dp_bit;
  logic [NUM_DIGITS-1:0]  an_nxt;
  logic                   lz_sup;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler tick, frame wrap and the index the scan moves to on this edge.
  always_comb begin
    tick    = (cnt == CNT_LAST);
    wrap    = tick && (index == IDX_LAST);
    idx_nxt = index;
    if (tick) begin
      if (index == IDX_LAST) idx_nxt = '0;
      else                   idx_nxt = index + 1'b1;
    end
  end

  // Display contents after this edge: a load on the wrap tick beats the
  // older shadow copy; otherwise a pending shadow copy moves in at the wrap.
  always_comb begin
    disp_data_nxt = disp_data;
    disp_dp_nxt   = disp_dp;
    if (wrap) begin
      if (bus.load) begin
        disp_data_nxt = bus.data_in;
        disp_dp_nxt   = bus.dp_in;
      end else if (pending) begin
        disp_data_nxt = shadow_data;
        disp_dp_nxt   = shadow_dp;
      end
    end
  end

  // Select the digit being lit next cycle. The pins are registered from the
  // next-state index/display so they change together with digit_tick.
  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    an_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        nib       = disp_data_nxt[4*i +: 4];
        dp_bit    = disp_dp_nxt[i];
        an_nxt[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every more-significant digit are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_sup     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (disp_data_nxt[4*i +: 4] == 4'h0);
      if (idx_nxt == IW'(i)) lz_sup = upper_zero;
    end
  end
`else
  // Leading zeros are displayed like any other digit.
  always_comb begin
    lz_sup = 1'b0;
  end
`endif

  // Prescaler, scan index and the shadow/display register pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      index       <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      disp_data   <= '0;
      disp_dp     <= '0;
    end else begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      index     <= idx_nxt;
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      if (bus.load) begin
        shadow_data <= bus.data_in;
        shadow_dp   <= bus.dp_in;
      end
      if (wrap)          pending <= 1'b0;
      else if (bus.load) pending <= 1'b1;
    end
  end

  // Registered pins and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      digit_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      digit_tick_q  <= tick;
      frame_start_q <= wrap;
      if (bus.blank || lz_sup) begin
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
        an_q  <= '1;
      end else begin
        seg_q <= hex7(nib);
        dp_q  <= ~dp_bit;
        an_q  <= an_nxt;
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.digit_tick  = digit_tick_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of seg7_scan_driver with
// NUM_DIGITS = 4, CLK_DIV = 4 (16-cycle frames).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int NONE = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      d1;
    logic [3:0]       p1;
    int               o1;
    logic [15:0]      d2;
    logic [3:0]       p2;
    int               o2;
    logic [3:0][6:0]  es;   // expected seg per digit in the following frame
    logic [3:0]       edp;  // expected active-low dp per digit
    logic [3:0]       eon;  // 1 = digit's anode expected active
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t cur;
  vec_t vecs [8];
  vec_t idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One 16-cycle frame starting on the frame_start cycle: check pins against
  // cur (with optional blank window) and apply the vector's loads.
  task automatic run_frame(input vec_t v, input int blank_lo, input int blank_hi);
    for (int o = 0; o < 16; o++) begin
      int         d;
      logic [3:0] ean;
      logic [6:0] es;
      logic       edp;
      d = o / 4;
      if (cur.eon[d] && !(o > blank_lo && o <= blank_hi + 1)) begin
        ean    = 4'hF;
        ean[d] = 1'b0;
        es     = cur.es[d];
        edp    = cur.edp[d];
      end else begin
        ean = 4'hF;
        es  = 7'h7F;
        edp = 1'b1;
      end
      chk("an", bus.an, ean);
      chk("seg", bus.seg, es);
      chk("dp", bus.dp, edp);
      chk("digit_tick", bus.digit_tick, (o % 4) == 0);
      chk("frame_start", bus.frame_start, o == 0);
      bus.load  = 1'b0;
      bus.blank = (o >= blank_lo && o <= blank_hi);
      if (o == v.o1) begin
        bus.load = 1'b1; bus.data_in = v.d1; bus.dp_in = v.p1;
      end
      if (o == v.o2) begin
        bus.load = 1'b1; bus.data_in = v.d2; bus.dp_in = v.p2;
      end
      @(negedge clk);
    end
    bus.load  = 1'b0;
    bus.blank = 1'b0;
  endtask

  // Count negedges until frame_start, bounded.
  task automatic count_to_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("first_an", bus.an, 4'hE);
        chk("first_seg", bus.seg, 7'h40);
      end
    end while (!bus.frame_start && n < 40);
  endtask

  initial begin
    int n;
    bus.load = 1'b0; bus.blank = 1'b0; bus.data_in = '0; bus.dp_in = '0;

    //           d1       p1      o1    d2       p2      o2    es                            edp      eon
    vecs[0] = '{16'h1A3F, 4'b0100, 6,    16'h0,   4'b0,   NONE, {7'h79,7'h08,7'h30,7'h0E}, 4'b1011, 4'hF};
    vecs[1] = '{16'h1111, 4'b0000, 3,    16'h2222,4'b0000,9,    {7'h24,7'h24,7'h24,7'h24}, 4'b1111, 4'hF};
    vecs[2] = '{16'h9999, 4'b1111, 4,    16'h0005,4'b0000,15,   {7'h40,7'h40,7'h40,7'h12}, 4'b1111, 4'hF};
    vecs[3] = '{16'h0040, 4'b0000, 12,   16'h0,   4'b0,   NONE, {7'h40,7'h40,7'h19,7'h40}, 4'b1111, 4'hF};
    vecs[4] = '{16'hEDCB, 4'b0001, 0,    16'h0,   4'b0,   NONE, {7'h06,7'h21,7'h46,7'h03}, 4'b1110, 4'hF};
    vecs[5] = '{16'h7654, 4'b1000, 15,   16'h0,   4'b0,   NONE, {7'h78,7'h02,7'h12,7'h19}, 4'b0111, 4'hF};
    vecs[6] = '{16'h8290, 4'b0000, 7,    16'h0,   4'b0,   NONE, {7'h00,7'h24,7'h10,7'h40}, 4'b1111, 4'hF};
    vecs[7] = '{16'h0000, 4'b1111, 1,    16'h0,   4'b0,   NONE, {7'h40,7'h40,7'h40,7'h40}, 4'b0000, 4'hF};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[2].eon = 4'b0001;
    vecs[3].eon = 4'b0011;
    vecs[7].eon = 4'b0001;
`endif
    idle = '{16'h0, 4'b0, NONE, 16'h0, 4'b0, NONE, {7'h40,7'h40,7'h40,7'h40}, 4'b1111, 4'hF};
`ifdef LEADING_ZERO_BLANK_EN
    idle.eon = 4'b0001;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_tick", bus.digit_tick, 1'b0);
    chk("rst_frame", bus.frame_start, 1'b0);
    rst = 1'b0;

    // Free-running scan with display = 0; first wrap 16 cycles after release.
    count_to_frame(n);
    chk("first_frame_cycles", n, 16);
    cur = idle;
    run_frame(idle, NONE, NONE);

    // Table: loads in frame k, checked unchanged in frame k and shown in k+1.
    for (int k = 0; k < 8; k++) begin
      run_frame(vecs[k], NONE, NONE);
      cur = vecs[k];
    end
    run_frame(idle, NONE, NONE);

    // blank for 10 cycles (offsets 2..11); pins follow one cycle later and
    // the scan keeps its free-running position.
    run_frame(idle, 2, 11);
    run_frame(idle, NONE, NONE);

    // Reset mid-frame with a coincident load: load is discarded.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.load = 1'b1; bus.data_in = 16'h1234; bus.dp_in = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    bus.load = 1'b0;
    chk("midrst_seg", bus.seg, 7'h7F);
    chk("midrst_an", bus.an, 4'hF);
    chk("midrst_tick", bus.digit_tick, 1'b0);
    count_to_frame(n);
    chk("midrst_frame_cycles", n, 16);
    cur = idle;
    run_frame(idle, NONE, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
